param_data_stack: RTL and testbench

- Parametrised successor to the processor's fixed data stack: WIDTH-bit entries, DEPTH entries, eight stack operations, plus depth tracking, full/empty flags, sticky overflow/underflow error flags and a high-water mark.
- Sits between the stack-control mux (source of `w`) and the ALU (reads `top`/`second`) in the stack processor.
- Driven by the control unit's stack-op field, one operation per slow-clock cycle.

---
 rtl/stack_pkg.sv | 47 ++++
 rtl/stack_op_decode.sv | 84 ++++++++
 rtl/param_data_stack.sv | 113 +++++++++++
 tb/tb_param_data_stack.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Definitions shared by the data stack and the control unit: stack-op encoding
// and the per-op need/delta table that drives the legality checks.
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP         = 3'd0,
        OP_PUSH        = 3'd1,
        OP_POP         = 3'd2,
        OP_REPLACE     = 3'd3,
        OP_POP_REPLACE = 3'd4,
        OP_SWAP        = 3'd5,
        OP_DUP         = 3'd6,
        OP_OVER        = 3'd7
    } stack_op_e;

    typedef enum logic [1:0] {
        DELTA_ZERO = 2'd0,
        DELTA_INC  = 2'd1,
        DELTA_DEC  = 2'd2
    } stack_delta_e;

    // Source of the word written into storage.
    typedef enum logic [1:0] {
        SEL_W      = 2'd0,
        SEL_TOP    = 2'd1,
        SEL_SECOND = 2'd2
    } stack_sel_e;

    // Minimum number of valid entries each op needs.
    function automatic logic [1:0] op_need(input stack_op_e op);
        case (op)
            OP_NOP, OP_PUSH:                     op_need = 2'd0;
            OP_POP, OP_REPLACE, OP_DUP:          op_need = 2'd1;
            OP_POP_REPLACE, OP_SWAP, OP_OVER:    op_need = 2'd2;
            default:                             op_need = 2'd0;
        endcase
    endfunction

    function automatic stack_delta_e op_delta(input stack_op_e op);
        case (op)
            OP_PUSH, OP_DUP, OP_OVER:            op_delta = DELTA_INC;
            OP_POP, OP_POP_REPLACE:              op_delta = DELTA_DEC;
            default:                             op_delta = DELTA_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/stack_op_decode.sv
// Combinational decode of one stack op against the current depth: depth
// direction, storage write port controls and the legality / error verdict.
module stack_op_decode
    import stack_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  stack_op_e        op,
    input  logic [CW-1:0]    depth,
    output logic             push,
    output logic             pop,
    output logic             wr_en,
    output logic [CW-1:0]    wr_idx,
    output stack_sel_e       wr_sel,
    output logic             swap_en,
    output logic [CW-1:0]    swap_idx,
    output logic             legal,
    output logic             ovf,
    output logic             unf
);

    logic [1:0]   need;
    stack_delta_e delta;
    logic [CW-1:0] idx_top;
    logic [CW-1:0] idx_second;

    assign need       = op_need(op);
    assign delta      = op_delta(op);
    assign idx_top    = depth - CW'(1);
    assign idx_second = depth - CW'(2);

    assign push = (delta == DELTA_INC);
    assign pop  = (delta == DELTA_DEC);

    // Underflow wins, so at most one error is reported for a given op.
    assign unf   = (depth < CW'(need));
    assign ovf   = !unf && push && (depth == CW'(DEPTH));
    assign legal = !unf && !ovf;

    // Raw write controls; the caller gates them with legal.
    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = depth;
        wr_sel   = SEL_W;
        swap_en  = 1'b0;
        swap_idx = idx_second;
        case (op)
            OP_PUSH: begin
                wr_en  = 1'b1;
                wr_idx = depth;
                wr_sel = SEL_W;
            end
            OP_REPLACE: begin
                wr_en  = 1'b1;
                wr_idx = idx_top;
                wr_sel = SEL_W;
            end
            OP_POP_REPLACE: begin
                wr_en  = 1'b1;
                wr_idx = idx_second;
                wr_sel = SEL_W;
            end
            OP_SWAP: begin
                wr_en   = 1'b1;
                wr_idx  = idx_top;
                wr_sel  = SEL_SECOND;
                swap_en = 1'b1;
            end
            OP_DUP: begin
                wr_en  = 1'b1;
                wr_idx = depth;
                wr_sel = SEL_TOP;
            end
            OP_OVER: begin
                wr_en  = 1'b1;
                wr_idx = depth;
                wr_sel = SEL_SECOND;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/param_data_stack.sv
// Parametrised processor data stack: storage, depth, high-water mark and
// sticky overflow/underflow flags; top/second feed the ALU combinationally.
module param_data_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [2:0]       stackOP,
    input  logic [WIDTH-1:0] w,
    input  logic             clear_err,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] second,
    output logic [CW-1:0]    depth,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow,
    output logic [CW-1:0]    high_water
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    stack_op_e     op;
    logic          push;
    logic          pop;
    logic          wr_en;
    logic [CW-1:0] wr_idx;
    stack_sel_e    wr_sel;
    logic          swap_en;
    logic [CW-1:0] swap_idx;
    logic          legal;
    logic          ovf;
    logic          unf;

    logic [WIDTH-1:0] wr_data;
    logic [CW-1:0]    depth_next;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    second_idx;

    assign op = stack_op_e'(stackOP);

    stack_op_decode #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_decode (
        .op       (op),
        .depth    (depth),
        .push     (push),
        .pop      (pop),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_sel   (wr_sel),
        .swap_en  (swap_en),
        .swap_idx (swap_idx),
        .legal    (legal),
        .ovf      (ovf),
        .unf      (unf)
    );

    always_comb begin
        case (wr_sel)
            SEL_TOP:    wr_data = top;
            SEL_SECOND: wr_data = second;
            default:    wr_data = w;
        endcase
    end

    always_comb begin
        depth_next = depth;
        if (legal && push) depth_next = depth + CW'(1);
        if (legal && pop)  depth_next = depth - CW'(1);
    end

    // Storage has no reset: entries at or above depth are never shown.
    always_ff @(posedge CLK) begin
        if (!reset && legal) begin
            if (wr_en)   mem[AW'(wr_idx)]   <= wr_data;
            if (swap_en) mem[AW'(swap_idx)] <= top;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            depth      <= '0;
            high_water <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            depth <= depth_next;
            if (depth_next > high_water) high_water <= depth_next;
            // A new error in the same cycle outranks clear_err.
            if (ovf)            overflow <= 1'b1;
            else if (clear_err) overflow <= 1'b0;
            if (unf)            underflow <= 1'b1;
            else if (clear_err) underflow <= 1'b0;
        end
    end

    assign top_idx    = AW'(depth - CW'(1));
    assign second_idx = AW'(depth - CW'(2));

    assign top    = (depth >= CW'(1)) ? mem[top_idx]    : '0;
    assign second = (depth >= CW'(2)) ? mem[second_idx] : '0;
    assign full   = (depth == CW'(DEPTH));
    assign empty  = (depth == '0);

endmodule

// File: tb/tb_param_data_stack.sv
// Directed bench for param_data_stack at WIDTH=16, DEPTH=4 with hand-computed
// expectations checked by immediate assertions.
module tb_param_data_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, REPL = 3'd3,
                           POPR = 3'd4, SWAP = 3'd5, DUP = 3'd6, OVER = 3'd7;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       stack_op;
    logic [WIDTH-1:0] w;
    logic             clear_err;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] second;
    logic [CW-1:0]    depth;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;
    logic [CW-1:0]    high_water;

    int total = 0;
    int bad   = 0;

    param_data_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .CLK        (clk),
        .reset      (reset),
        .stackOP    (stack_op),
        .w          (w),
        .clear_err  (clear_err),
        .top        (top),
        .second     (second),
        .depth      (depth),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .underflow  (underflow),
        .high_water (high_water)
    );

    always #5 clk = ~clk;

    // Apply one op for one rising edge, then sample 1 time unit later.
    task automatic step(input logic rst, input logic [2:0] op,
                        input logic [WIDTH-1:0] data, input logic clr);
        reset     = rst;
        stack_op  = op;
        w         = data;
        clear_err = clr;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        stack_op  = NOP;
        w         = '0;
        clear_err = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [15:0] e_top,
                               input logic [15:0] e_second, input int e_depth);
        check({tag, ".top"},    top,    e_top);
        check({tag, ".second"}, second, e_second);
        check({tag, ".depth"},  depth,  e_depth);
    endtask

    initial begin
        reset = 1'b1; stack_op = NOP; w = '0; clear_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        step(1'b1, NOP, 16'h0, 1'b0);
        check_state("rst", 16'h0, 16'h0, 0);
        check("rst.empty", empty, 1);
        check("rst.full", full, 0);
        check("rst.hw", high_water, 0);
        check("rst.ovf", overflow, 0);
        check("rst.unf", underflow, 0);

        // Three pushes
        step(1'b0, PUSH, 16'h0011, 1'b0);
        check_state("push1", 16'h0011, 16'h0, 1);
        step(1'b0, PUSH, 16'h0022, 1'b0);
        step(1'b0, PUSH, 16'h0033, 1'b0);
        check_state("push3", 16'h0033, 16'h0022, 3);
        check("push3.hw", high_water, 3);
        check("push3.empty", empty, 0);

        // SWAP then POP_REPLACE
        step(1'b0, SWAP, 16'hDEAD, 1'b0);
        check_state("swap", 16'h0022, 16'h0033, 3);
        step(1'b0, POPR, 16'h0055, 1'b0);
        check_state("popr", 16'h0055, 16'h0011, 2);
        check("popr.hw", high_water, 3);

        // Fill to DEPTH, then overflow
        step(1'b0, PUSH, 16'h0066, 1'b0);
        step(1'b0, PUSH, 16'h0077, 1'b0);
        check_state("fill", 16'h0077, 16'h0066, 4);
        check("fill.full", full, 1);
        check("fill.hw", high_water, 4);
        step(1'b0, PUSH, 16'h9999, 1'b0);
        check_state("ovf", 16'h0077, 16'h0066, 4);
        check("ovf.flag", overflow, 1);
        check("ovf.unf", underflow, 0);

        // Illegal op with clear_err in the same cycle: error wins
        step(1'b0, PUSH, 16'h1234, 1'b1);
        check("ovfclr.flag", overflow, 1);
        check_state("ovfclr", 16'h0077, 16'h0066, 4);
        step(1'b0, NOP, 16'h0, 1'b1);
        check("clr.ovf", overflow, 0);
        step(1'b0, DUP, 16'h0, 1'b0);
        check("dupfull.ovf", overflow, 1);
        check("dupfull.depth", depth, 4);
        step(1'b0, NOP, 16'h0, 1'b1);

        // Underflow from empty
        step(1'b1, NOP, 16'h0, 1'b0);
        step(1'b0, POP, 16'h0, 1'b0);
        check("unf.flag", underflow, 1);
        check("unf.ovf", overflow, 0);
        check_state("unf", 16'h0, 16'h0, 0);
        step(1'b0, PUSH, 16'h0007, 1'b0);
        check("unf.sticky", underflow, 1);
        step(1'b0, NOP, 16'h0, 1'b1);
        check("unf.clr", underflow, 0);
        step(1'b0, OVER, 16'h0, 1'b0);
        check("over1.unf", underflow, 1);
        check_state("over1", 16'h0007, 16'h0, 1);

        // PUSH, DUP, OVER from empty, then reset with PUSH same cycle
        step(1'b1, NOP, 16'h0, 1'b0);
        step(1'b0, PUSH, 16'h00AA, 1'b0);
        step(1'b0, DUP, 16'h0, 1'b0);
        step(1'b0, OVER, 16'h0, 1'b0);
        check_state("dupover", 16'h00AA, 16'h00AA, 3);
        step(1'b1, PUSH, 16'h5A5A, 1'b1);
        check_state("rstpush", 16'h0, 16'h0, 0);
        check("rstpush.hw", high_water, 0);

        // OVER with distinct values, REPLACE, POP
        step(1'b0, PUSH, 16'h0001, 1'b0);
        step(1'b0, PUSH, 16'h0002, 1'b0);
        step(1'b0, OVER, 16'h0, 1'b0);
        check_state("over", 16'h0001, 16'h0002, 3);
        step(1'b0, REPL, 16'hBEEF, 1'b0);
        check_state("repl", 16'hBEEF, 16'h0002, 3);
        step(1'b0, POP, 16'h0, 1'b0);
        check_state("pop", 16'h0002, 16'h0001, 2);
        check("pop.hw", high_water, 3);
        check("pop.flags", {overflow, underflow}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
